// File: rtl/bram_port_sequencer_if.sv
// Request/response handshake bundle between a client and the BRAM port sequencer.
// The client side drives requests and accepts responses.
interface bram_port_sequencer_if #(
  parameter int unsigned NB_COL     = 4,
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 9
) ();

  logic                            req_valid;
  logic                            req_ready;
  logic [ADDR_WIDTH-1:0]           req_addr;
  logic [NB_COL-1:0]               req_we;
  logic [NB_COL*COL_WIDTH-1:0]     req_wdata;
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [NB_COL*COL_WIDTH-1:0]     rsp_data;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/bram_port_sequencer.sv
// Sequences valid/ready read/write requests onto one byte-enable BRAM port and
// returns read data in order through a credit-protected response FIFO.
module bram_port_sequencer #(
  parameter int unsigned NB_COL       = 4,
  parameter int unsigned COL_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clka,
  input  logic                        rsta,
  bram_port_sequencer_if.slave        bus,
  output logic [ADDR_WIDTH-1:0]       addra,
  output logic [NB_COL*COL_WIDTH-1:0] dina,
  output logic [NB_COL-1:0]           wea,
  output logic                        ena,
  output logic                        regcea,
  output logic                        bram_rst,
  input  logic [NB_COL*COL_WIDTH-1:0] douta
);

  localparam int unsigned W  = NB_COL * COL_WIDTH;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [READ_LATENCY-1:0] vld;
  logic [READ_LATENCY-1:0] vld_n;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           count;
  logic [CW:0]             outstanding;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [W-1:0]            mem [FIFO_DEPTH];
  logic                    is_wr;
  logic                    credit_ok;
  logic                    accept;
  logic                    rd_accept;
  logic                    push;
  logic                    pop;

  // Credit counts reads already in the BRAM pipe plus data parked in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      inflight = inflight + CW'(vld[i]);
    end
  end

  assign outstanding = {1'b0, inflight} + {1'b0, count};
  assign credit_ok   = outstanding < (CW+1)'(FIFO_DEPTH);
  assign is_wr       = |bus.req_we;

  assign bus.req_ready = !rsta && (is_wr || credit_ok);
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !is_wr;

  assign addra    = bus.req_addr;
  assign dina     = bus.req_wdata;
  assign ena      = accept;
  assign wea      = accept ? bus.req_we : '0;
  assign regcea   = 1'b1;
  assign bram_rst = rsta;

  // Final pipe stage set means douta carries that read's data this cycle.
  assign push          = vld[READ_LATENCY-1];
  assign bus.rsp_valid = !rsta && (count != '0);
  assign bus.rsp_data  = mem[rd_ptr];
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  assign vld_n = READ_LATENCY'({vld, rd_accept});

  always_ff @(posedge clka) begin
    if (rsta) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      vld <= vld_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage only; contents are meaningless until written.
  always_ff @(posedge clka) begin
    if (!rsta && push) mem[wr_ptr] <= douta;
  end

  always_ff @(posedge clka) begin
    if (!rsta) begin
      assert (!(push && !pop && count == CW'(FIFO_DEPTH)))
        else $error("response FIFO overflow");
      assert (!(push && count == CW'(FIFO_DEPTH)))
        else $error("push into full response FIFO");
    end
  end

endmodule

// File: tb/tb_bram_port_sequencer.sv
// Randomized and directed bench for bram_port_sequencer against a transaction-level
// model: a reference memory plus a queue of outstanding reads stamped with accept cycle.
module tb_bram_port_sequencer;

  localparam int unsigned NB_COL       = 4;
  localparam int unsigned COL_WIDTH    = 8;
  localparam int unsigned ADDR_WIDTH   = 9;
  localparam int unsigned READ_LATENCY = 2;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned W            = NB_COL * COL_WIDTH;
  localparam int unsigned WORDS        = 1 << ADDR_WIDTH;

  logic                  clk = 1'b0;
  logic                  rsta = 1'b1;
  logic [ADDR_WIDTH-1:0] addra;
  logic [W-1:0]          dina;
  logic [NB_COL-1:0]     wea;
  logic                  ena;
  logic                  regcea;
  logic                  bram_rst;
  logic [W-1:0]          douta;

  bram_port_sequencer_if #(.NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  bram_port_sequencer #(
    .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .READ_LATENCY(READ_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clka(clk), .rsta(rsta), .bus(bus),
    .addra(addra), .dina(dina), .wea(wea), .ena(ena),
    .regcea(regcea), .bram_rst(bram_rst), .douta(douta)
  );

  always #5 clk = ~clk;

  // Byte-enable BRAM with an output register (two-cycle read).
  logic [W-1:0] bram [WORDS];
  logic [W-1:0] rd_q;
  always @(posedge clk) begin
    if (ena) begin
      for (int l = 0; l < int'(NB_COL); l++)
        if (wea[l]) bram[addra][l*COL_WIDTH +: COL_WIDTH] <= dina[l*COL_WIDTH +: COL_WIDTH];
      rd_q <= bram[addra];
    end
    if (bram_rst) douta <= '0;
    else if (regcea) douta <= rd_q;
  end

  typedef struct { logic [W-1:0] data; int cyc; } rsp_t;
  rsp_t         exp_q[$];
  logic [W-1:0] ref_mem [WORDS];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  logic         acc;
  logic         ov;
  logic [W-1:0] od;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the model mid-cycle, advance the model.
  task automatic step(input logic v, input logic [ADDR_WIDTH-1:0] a, input logic [NB_COL-1:0] we,
                      input logic [W-1:0] wd, input logic rr, input logic rs);
    logic exp_ready, exp_acc, exp_valid;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_we    = we;
    bus.req_wdata = wd;
    bus.rsp_ready = rr;
    rsta          = rs;
    @(negedge clk);
    exp_ready = !rs && (we != '0 || exp_q.size() < int'(FIFO_DEPTH));
    exp_acc   = v && exp_ready;
    exp_valid = !rs && exp_q.size() > 0 && (exp_q[0].cyc + int'(READ_LATENCY) + 1 <= cyc);
    check_eq("req_ready", W'(bus.req_ready), W'(exp_ready));
    check_eq("ena", W'(ena), W'(exp_acc));
    check_eq("wea", W'(wea), exp_acc ? W'(we) : '0);
    check_eq("rsp_valid", W'(bus.rsp_valid), W'(exp_valid));
    check_eq("bram_rst", W'(bram_rst), W'(rs));
    check_eq("regcea", W'(regcea), W'(1));
    if (exp_valid && bus.rsp_valid) check_eq("rsp_data", bus.rsp_data, exp_q[0].data);
    acc = v && bus.req_ready;
    ov  = bus.rsp_valid;
    od  = bus.rsp_data;
    if (rs) begin
      exp_q.delete();
    end else begin
      if (exp_valid && rr) void'(exp_q.pop_front());
      if (exp_acc) begin
        if (we != '0) begin
          for (int l = 0; l < int'(NB_COL); l++)
            if (we[l]) ref_mem[a][l*COL_WIDTH +: COL_WIDTH] = wd[l*COL_WIDTH +: COL_WIDTH];
        end else begin
          exp_q.push_back('{data: ref_mem[a], cyc: cyc});
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic rr, input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, rr, 1'b0);
  endtask

  initial begin
    int t0, first, last, nv, nacc, npop;
    logic found;
    for (int i = 0; i < int'(WORDS); i++) begin
      bram[i]    = W'($urandom);
      ref_mem[i] = bram[i];
    end
    bram[5] = 32'hA5A5_0001; ref_mem[5] = 32'hA5A5_0001;
    bram[3] = 32'hFFFF_FFFF; ref_mem[3] = 32'hFFFF_FFFF;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_we = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;

    // Reset with requests pending: nothing may be accepted.
    step(1'b1, 9'd7, 4'hF, 32'h1234_5678, 1'b1, 1'b1);
    step(1'b1, 9'd7, 4'h0, '0, 1'b1, 1'b1);

    // Single read: first response three cycles after acceptance, held until taken.
    t0 = cyc;
    step(1'b1, 9'd5, 4'h0, '0, 1'b0, 1'b0);
    check_eq("single_acc", W'(acc), W'(1));
    first = -1;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, '0, '0, '0, 1'b0, 1'b0);
      if (ov && first < 0) begin first = cyc - 1; check_eq("single_data", od, 32'hA5A5_0001); end
    end
    check_eq("single_latency", W'(first - t0), W'(3));
    idle(1'b1, 2);

    // Byte-enable write then immediate read of the same word.
    step(1'b1, 9'd3, 4'b0101, 32'h1122_3344, 1'b0, 1'b0);
    check_eq("be_wr_acc", W'(acc), W'(1));
    step(1'b1, 9'd3, 4'h0, '0, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      if (ov) begin found = 1'b1; check_eq("raw_data", od, 32'hFF22_FF44); end
    end
    if (!found) check_eq("raw_timeout", W'(found), W'(1));
    idle(1'b1, 2);

    // Streaming 16 reads at full rate.
    t0 = cyc; first = -1; last = -1; nv = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, ADDR_WIDTH'(i), 4'h0, '0, 1'b1, 1'b0);
      check_eq("stream_acc", W'(acc), W'(1));
      if (ov) begin nv++; if (first < 0) first = cyc - 1; last = cyc - 1; end
    end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      if (ov) begin nv++; if (first < 0) first = cyc - 1; last = cyc - 1; end
    end
    check_eq("stream_count", W'(nv), W'(16));
    check_eq("stream_first", W'(first - t0), W'(3));
    check_eq("stream_last", W'(last - t0), W'(18));

    // Backpressure: only FIFO_DEPTH reads get credit; writes still pass.
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ADDR_WIDTH'(40 + i), 4'h0, '0, 1'b0, 1'b0);
      if (acc) nacc++;
    end
    check_eq("bp_accepted", W'(nacc), W'(4));
    step(1'b1, 9'd50, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check_eq("bp_write_acc", W'(acc), W'(1));
    npop = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      if (ov) npop++;
    end
    check_eq("bp_drained", W'(npop), W'(4));
    step(1'b1, 9'd50, 4'h0, '0, 1'b1, 1'b0);
    check_eq("bp_resume", W'(acc), W'(1));
    idle(1'b1, 4);

    // Hold three in the FIFO, then push and pop together across the pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, ADDR_WIDTH'(60 + i), 4'h0, '0, 1'b0, 1'b0);
    idle(1'b0, 3);
    for (int i = 0; i < 10; i++) step(1'b1, ADDR_WIDTH'(70 + i), 4'h0, '0, 1'b1, 1'b0);
    idle(1'b1, 6);

    // Reset with data both in flight and parked; no stale response may surface.
    for (int i = 0; i < 4; i++) step(1'b1, ADDR_WIDTH'(80 + i), 4'h0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    check_eq("rst_rsp_valid", W'(bus.rsp_valid), W'(0));
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ADDR_WIDTH'(90 + i), 4'h0, '0, 1'b0, 1'b0);
      if (acc) nacc++;
    end
    check_eq("rst_credit", W'(nacc), W'(4));
    idle(1'b1, 8);

    // Random traffic with narrow address range and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic v, rr, rs;
      logic [NB_COL-1:0] we;
      v  = ($urandom % 4) != 0;
      we = (($urandom % 3) == 0) ? NB_COL'($urandom) : '0;
      rr = ($urandom % 4) != 0;
      rs = ($urandom % 250) == 0;
      step(v, ADDR_WIDTH'($urandom % 32), we, W'($urandom), rr, rs);
    end
    idle(1'b1, 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
